// File: rtl/butterfly_multiplier.sv
// Sequential signed shift-add multiplier with fixed-point scaling and saturation.
// A request is accepted only in IDLE; the magnitudes of the operands are latched
// and accumulated LSB-first over WIDTH cycles. The sign is applied in FINAL,
// then a guard window blocks new requests before the FSM returns to IDLE.
//
// Handshake: MULEN is a level request sampled only in IDLE. Each accepted
// request produces exactly one reg_MUL pulse, one cycle wide, unless rst
// intervenes. product/product_full/ovf are meaningful while reg_MUL=1;
// product and product_full then hold until the next result.
module butterfly_multiplier #(
    parameter int WIDTH        = 8,
    parameter int FRAC_BITS    = 0,
    parameter int GUARD_CYCLES = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 MULEN,
    input  logic [WIDTH-1:0]     c,
    input  logic [WIDTH-1:0]     d,
    output logic [WIDTH-1:0]     product,
    output logic                 reg_MUL,
    output logic [2*WIDTH-1:0]   product_full,
    output logic                 ovf,
    output logic                 busy,
    output logic [1:0]           dbg_state_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BUSY  = 2'd1,
        S_FINAL = 2'd2,
        S_GUARD = 2'd3
    } state_e;

    // One counter serves both the iteration count and the guard window.
    localparam int CNT_MAX = (WIDTH > GUARD_CYCLES) ? WIDTH : GUARD_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] LAST_ITER  = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] LAST_GUARD = CNT_W'(GUARD_CYCLES - 1);

    localparam logic [WIDTH-1:0]   ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [2*WIDTH-1:0] ONE_2W = {{(2*WIDTH-1){1'b0}}, 1'b1};

    // Saturation bounds expressed at full product width.
    localparam logic signed [2*WIDTH-1:0] SAT_MAX = {{(WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [2*WIDTH-1:0] SAT_MIN = {{(WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

    state_e               state_q, state_d;
    logic                 sign_q, sign_d;
    logic [2*WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]     product_q, product_d;
    logic [2*WIDTH-1:0]   full_q, full_d;
    logic                 reg_mul_q, reg_mul_d;
    logic                 ovf_q, ovf_d;

    logic [WIDTH-1:0]          c_mag, d_mag;
    logic signed [2*WIDTH-1:0] p_full;
    logic signed [2*WIDTH-1:0] s_full;
    logic                      sat_hi, sat_lo;
    logic [WIDTH-1:0]          sat_val;

    // Operand magnitudes; the most negative value maps to 2^(WIDTH-1) unsigned.
    always_comb begin
        c_mag = c[WIDTH-1] ? ((~c) + ONE_W) : c;
        d_mag = d[WIDTH-1] ? ((~d) + ONE_W) : d;
    end

    // Signed product, floor scaling and saturation of the finished accumulator.
    always_comb begin
        p_full  = sign_q ? ((~acc_q) + ONE_2W) : acc_q;
        s_full  = p_full >>> FRAC_BITS;
        sat_hi  = (s_full > SAT_MAX);
        sat_lo  = (s_full < SAT_MIN);
        sat_val = s_full[WIDTH-1:0];
        if (sat_hi) begin
            sat_val = {1'b0, {(WIDTH-1){1'b1}}};
        end else if (sat_lo) begin
            sat_val = {1'b1, {(WIDTH-1){1'b0}}};
        end
    end

    // Next-state and datapath updates; strobe and flag default low every cycle.
    always_comb begin
        state_d   = state_q;
        sign_d    = sign_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        full_d    = full_q;
        reg_mul_d = 1'b0;
        ovf_d     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (MULEN) begin
                    sign_d   = c[WIDTH-1] ^ d[WIDTH-1];
                    mcand_d  = {{WIDTH{1'b0}}, c_mag};
                    mplier_d = d_mag;
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = S_BUSY;
                end
            end
            S_BUSY: begin
                acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                if (cnt_q == LAST_ITER) begin
                    cnt_d   = '0;
                    state_d = S_FINAL;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_FINAL: begin
                product_d = sat_val;
                full_d    = p_full;
                ovf_d     = sat_hi | sat_lo;
                reg_mul_d = 1'b1;
                cnt_d     = '0;
                state_d   = S_GUARD;
            end
            S_GUARD: begin
                if (cnt_q == LAST_GUARD) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers, cleared asynchronously by rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            sign_q    <= 1'b0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            product_q <= '0;
            full_q    <= '0;
            reg_mul_q <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            sign_q    <= sign_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
            full_q    <= full_d;
            reg_mul_q <= reg_mul_d;
            ovf_q     <= ovf_d;
        end
    end

    assign product      = product_q;
    assign product_full = full_q;
    assign reg_MUL      = reg_mul_q;
    assign ovf          = ovf_q;
    assign busy         = (state_q != S_IDLE);
    assign dbg_state_o  = state_q;

endmodule

// File: doc/butterfly_multiplier.md
BUTTERFLY_MULTIPLIER -- requirements
Module: butterfly_multiplier

Interface
REQ-001 Parameter WIDTH, default 8: operand and product width in bits.
REQ-002 Parameter FRAC_BITS, default 0: number of fractional bits removed from the full product, 0..WIDTH-1.
REQ-003 Parameter GUARD_CYCLES, default 1: number of post-result cycles in which MULEN is ignored, minimum 1.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 MULEN  input  1  multiply request, level-sensitive, sampled only in IDLE.
REQ-007 c  input  WIDTH  signed multiplicand, two's complement.
REQ-008 d  input  WIDTH  signed multiplier, two's complement.
REQ-009 product  output  WIDTH  signed scaled and saturated result, registered, held until the next result.
REQ-010 reg_MUL  output  1  result-valid strobe, registered, one cycle wide.
REQ-011 product_full  output  2*WIDTH  exact signed product, registered and updated together with product.
REQ-012 ovf  output  1  saturation flag, registered, valid only while reg_MUL=1, otherwise 0.
REQ-013 busy  output  1  high in every state except IDLE.

Function
REQ-014 The FSM SHALL have the states IDLE, BUSY, FINAL and GUARD, one-hot or encoded.
REQ-015 IDLE with MULEN=1 at edge E0 SHALL:
- latch c and d;
- latch the sign as c[MSB] XOR d[MSB];
- load the magnitudes |c| and |d| as unsigned WIDTH-bit values (|-2^(WIDTH-1)| = 2^(WIDTH-1), no overflow);
- clear the accumulator and iteration counter;
- go to BUSY.
REQ-016 IDLE with MULEN=0 SHALL hold all state.
REQ-017 BUSY SHALL perform one shift-add iteration per cycle (LSB-first multiplier bit) for exactly WIDTH cycles, then go to FINAL.
REQ-018 FINAL SHALL apply the sign to the 2*WIDTH-bit magnitude, giving the exact product P.
REQ-019 FINAL SHALL compute S = P arithmetically shifted right by FRAC_BITS (truncation toward minus infinity).
REQ-020 FINAL SHALL saturate S to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
REQ-021 On the FINAL exit edge, FINAL SHALL register product=sat(S), product_full=P, ovf=(S out of range), reg_MUL=1, then go to GUARD.
REQ-022 reg_MUL SHALL be high only in the first GUARD cycle; ovf SHALL return to 0 with it.
REQ-023 GUARD SHALL last GUARD_CYCLES cycles, ignore MULEN, then return to IDLE.
REQ-024 Latency: with MULEN sampled at E0, reg_MUL SHALL be high in the cycle after edge E0+WIDTH+1 (E9 for WIDTH=8).
REQ-025 Back-to-back: MULEN held high SHALL start the next operation at the first IDLE edge, so the request period is WIDTH+2+GUARD_CYCLES cycles (11 for the defaults).
REQ-026 Changes on c or d after E0 SHALL have no effect on the operation in progress.
REQ-027 MULEN deasserted during BUSY, FINAL or GUARD SHALL NOT abort; the result SHALL still be delivered.
REQ-028 product and product_full SHALL retain the last result through IDLE and subsequent BUSY phases.
REQ-029 A zero operand SHALL still take the full latency and SHALL yield product=0, product_full=0, ovf=0.

Reset
REQ-030 rst=1 SHALL immediately force state=IDLE, and product, product_full, reg_MUL, ovf, busy, accumulator and counter to 0, independent of clk.
REQ-031 Reset asserted mid-operation SHALL discard the operation with no reg_MUL pulse; the first edge after rst deasserts SHALL sample MULEN as in IDLE.

Verification
REQ-032 The bench SHALL cover these scenarios:
- WIDTH=8, FRAC_BITS=0: c=3, d=-5, MULEN pulsed at E0 -> reg_MUL high after E9 only; product=-15; product_full=-15; ovf=0.
- c=-128, d=-128 -> product_full=16384, product=127, ovf=1.
- c=16, d=-16 -> product_full=-256, product=-128, ovf=1.
- FRAC_BITS=4: c=32 (2.0), d=24 (1.5) -> product_full=768, product=48 (3.0), ovf=0; c=-1, d=1 -> product=-1 (floor).
- MULEN held high, operands changed one cycle after each reg_MUL -> reg_MUL pulses 11 cycles apart, each product matches its own operands; operand changes during BUSY are ignored.
- rst asserted at BUSY cycle 4 -> all outputs 0 at once, no reg_MUL; MULEN dropped mid-BUSY in a separate run -> result still delivered at E9.
